// File: rtl/pu_msp430_dac_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : pu_msp430_dac_rx_if
// Description : Bundles the three SPI lines (sclk, sync_n, din) that run from
//               the MSP430 SPI DAC peripheral to its receive-side model.
// Revision    : 1.0 - initial release
// ============================================================================
interface pu_msp430_dac_rx_if;
  logic sclk;
  logic sync_n;
  logic din;

  // The frame source drives the lines.
  modport master (output sclk, output sync_n, output din);
  // The DAC receiver only observes them.
  modport slave  (input sclk, input sync_n, input din);
endinterface
`default_nettype wire

// File: rtl/pu_msp430_dac_rx.sv
`default_nettype none
// ============================================================================
// Module      : pu_msp430_dac_rx
// Description : Receive side of the MSP430 SPI DAC link. Oversamples the
//               sclk/sync_n/din lines in the mclk domain, deserialises frames
//               {2'b00, pd1, pd0, val[11:0]}, commits valid frames, counts
//               malformed ones and drives a first-order sigma-delta bitstream.
// Revision    : 1.0 - initial release
// ============================================================================
module pu_msp430_dac_rx #(
  parameter int FRAME_BITS = 16,
  parameter int ERR_CNT_WD = 8
) (
  input  logic                  mclk,
  input  logic                  puc_rst_n,
  pu_msp430_dac_rx_if.slave     spi,
  input  logic                  err_clr,
  output logic [11:0]           dac_val,
  output logic [1:0]            dac_pd,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [ERR_CNT_WD-1:0] err_cnt,
  output logic                  sd_out,
  output logic                  sd_oe
);

  localparam logic [1:0] c_st_wait_idle = 2'd0;
  localparam logic [1:0] c_st_idle      = 2'd1;
  localparam logic [1:0] c_st_shift     = 2'd2;

  localparam logic [4:0] c_cnt_frame = 5'(FRAME_BITS);
  localparam logic [4:0] c_cnt_max   = 5'(FRAME_BITS + 1);
  localparam logic [ERR_CNT_WD-1:0] c_err_max = {ERR_CNT_WD{1'b1}};

  // Input capture: [0],[1] synchronise, [2] is history for edge detection.
  // din is only ever sampled, never edge-detected, so it needs no history flop.
  logic [2:0]  r_sclk_sync;
  logic [2:0]  r_sync_n_sync;
  logic [1:0]  r_din_sync;
  // Counts mclk edges since reset until the sync_n chain holds real samples;
  // otherwise the reset value (high) would look like an idle line and a frame
  // in progress at reset would be picked up half way.
  logic [1:0]  r_settle;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  // Only the low 14 received bits matter; the two leading pad bits are
  // shifted out and never looked at.
  logic [13:0] r_shift;
  logic [4:0]  r_bit_cnt;

  logic [11:0] r_dac_val;
  logic [1:0]  r_dac_pd;
  logic        r_frame_done;
  logic        r_frame_err;
  logic [ERR_CNT_WD-1:0] r_err_cnt;
  logic [12:0] r_acc;

  logic w_sclk_fe;
  logic w_sync_rise;
  logic w_sync_fall;
  logic w_din;
  logic w_frame_start;
  logic w_shift_en;
  logic w_frame_end;
  logic w_frame_ok;
  logic w_frame_bad;
  logic [1:0] w_pd_next;

  assign w_sclk_fe   = r_sclk_sync[2] & ~r_sclk_sync[1];
  assign w_sync_rise = r_sync_n_sync[1] & ~r_sync_n_sync[2];
  assign w_sync_fall = ~r_sync_n_sync[1] & r_sync_n_sync[2];
  assign w_din       = r_din_sync[1];

  // Synchronise and history-register the SPI lines.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_sclk_sync   <= 3'b000;
      r_sync_n_sync <= 3'b111;
      r_din_sync    <= 2'b00;
      r_settle      <= 2'd0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[1:0], spi.sclk};
      r_sync_n_sync <= {r_sync_n_sync[1:0], spi.sync_n};
      r_din_sync    <= {r_din_sync[0], spi.din};
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) r_state <= c_st_wait_idle;
    else            r_state <= w_state_next;
  end

  // Frame FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_wait_idle: if (r_settle == 2'd3 && r_sync_n_sync[1]) w_state_next = c_st_idle;
      c_st_idle:      if (w_sync_fall) w_state_next = c_st_shift;
      c_st_shift:     if (w_sync_rise) w_state_next = c_st_idle;
      default:        w_state_next = c_st_wait_idle;
    endcase
  end

  // Frame FSM outputs: strobes for the datapath.
  always_comb begin
    w_frame_start = 1'b0;
    w_shift_en    = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      c_st_idle:  w_frame_start = w_sync_fall;
      c_st_shift: begin
        w_shift_en  = w_sclk_fe & ~w_sync_rise;
        w_frame_end = w_sync_rise;
      end
      default: ;
    endcase
  end

  assign w_frame_ok  = w_frame_end & (r_bit_cnt == c_cnt_frame);
  assign w_frame_bad = w_frame_end & (r_bit_cnt != c_cnt_frame);
  assign w_pd_next   = w_frame_ok ? r_shift[13:12] : r_dac_pd;

  // Deserialiser: MSB-first shift and saturating falling-edge counter.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_frame_start) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[12:0], w_din};
      if (r_bit_cnt != c_cnt_max) r_bit_cnt <= r_bit_cnt + 5'd1;
    end
  end

  // Commit a well-formed frame to the DAC output registers.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_dac_val    <= '0;
      r_dac_pd     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_ok;
      if (w_frame_ok) begin
        r_dac_val <= r_shift[11:0];
        r_dac_pd  <= r_shift[13:12];
      end
    end
  end

  // Sticky error flag and saturating error counter; a new error beats err_clr.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else if (w_frame_bad) begin
      r_frame_err <= 1'b1;
      if (err_clr)                     r_err_cnt <= ERR_CNT_WD'(1);
      else if (r_err_cnt != c_err_max) r_err_cnt <= r_err_cnt + ERR_CNT_WD'(1);
    end else if (err_clr) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end
  end

  // First-order sigma-delta; gated by the power-down bits being committed
  // this edge so power-down and the commit land in the same cycle.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)              r_acc <= '0;
    else if (w_pd_next != 2'b00) r_acc <= '0;
    else                         r_acc <= {1'b0, r_acc[11:0]} + {1'b0, r_dac_val};
  end

  assign dac_val    = r_dac_val;
  assign dac_pd     = r_dac_pd;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign err_cnt    = r_err_cnt;
  assign sd_out     = r_acc[12];
  assign sd_oe      = ~(r_dac_pd == 2'b11);

endmodule
`default_nettype wire
